// File: rtl/my9262_rx.sv
`default_nettype none
// ============================================================================
// Module   : my9262_rx
// Brief    : Rebuilds MY9262 serial traffic: words, latch class, Gck counts.
// Revision : 1.0
// ============================================================================
module my9262_rx #(
  parameter int WORD_W      = 16,
  parameter int FRAME_WORDS = 32,
  parameter int OVR_EDGES   = 2
) (
  input  logic                           CLK_60M,
  input  logic                           RST,
  input  logic                           my9262_Dclk,
  input  logic                           my9262_Di,
  input  logic                           my9262_Lat,
  input  logic                           my9262_Gck,
  output logic [WORD_W-1:0]              rx_Data,
  output logic                           rx_Valid,
  output logic [$clog2(FRAME_WORDS)-1:0] rx_Word_Idx,
  output logic                           lat_Event,
  output logic                           lat_Type,
  output logic [9:0]                     lat_Bits,
  output logic [15:0]                    gck_Cnt,
  output logic                           frame_Err
);

  localparam int                IDX_W    = $clog2(FRAME_WORDS);
  localparam int                BIT_W    = $clog2(WORD_W);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(WORD_W - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_WORDS - 1);
  localparam logic [9:0]        BITS_MAX = 10'h3FF;
  localparam logic [15:0]       GCK_MAX  = 16'hFFFF;

  // [0],[1] synchronise, [2] holds the previous value for edge detection
  logic [2:0] dclk_q, lat_q, gck_q;
  logic [1:0] di_q;

  logic [WORD_W-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]  word_idx_q, word_idx_d;
  logic [9:0]        lbits_q, lbits_d;
  logic [2:0]        win_q, win_d;
  logic [15:0]       gacc_q, gacc_d;

  logic [WORD_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic [IDX_W-1:0]  rx_idx_q, rx_idx_d;
  logic              lat_event_q, lat_event_d;
  logic              lat_type_q, lat_type_d;
  logic [9:0]        lat_bits_q, lat_bits_d;
  logic [15:0]       gck_cnt_q, gck_cnt_d;
  logic              frame_err_q, frame_err_d;

  logic dclk_rise, lat_rise, lat_fall, gck_rise;

  assign dclk_rise = dclk_q[1] & ~dclk_q[2];
  assign lat_rise  = lat_q[1]  & ~lat_q[2];
  assign lat_fall  = ~lat_q[1] &  lat_q[2];
  assign gck_rise  = gck_q[1]  & ~gck_q[2];

  always_comb begin
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    word_idx_d  = word_idx_q;
    lbits_d     = lbits_q;
    win_d       = win_q;
    gacc_d      = gacc_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_idx_d    = rx_idx_q;
    lat_event_d = 1'b0;
    lat_type_d  = lat_type_q;
    lat_bits_d  = lat_bits_q;
    gck_cnt_d   = gck_cnt_q;
    frame_err_d = frame_err_q;

    if (lat_rise) win_d = '0;

    // A Dclk edge is applied before a coincident Lat fall is evaluated
    if (dclk_rise) begin
      shift_d = {shift_q[WORD_W-2:0], di_q[1]};
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d  = '0;
        rx_data_d  = shift_d;
        rx_valid_d = 1'b1;
        rx_idx_d   = word_idx_q;
        word_idx_d = (word_idx_q == LAST_IDX) ? '0 : word_idx_q + 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
      if (lbits_q != BITS_MAX) lbits_d = lbits_q + 1'b1;
      if ((lat_q[1] || lat_fall) && win_d != 3'd7) win_d = win_d + 1'b1;
    end

    if (lat_fall) begin
      lat_event_d = 1'b1;
      lat_type_d  = (32'(win_d) >= OVR_EDGES);
      lat_bits_d  = lbits_d;
      lbits_d     = '0;
      gck_cnt_d   = gacc_q;
      gacc_d      = '0;
      if (bit_cnt_d != '0) frame_err_d = 1'b1;
      bit_cnt_d   = '0;
      shift_d     = '0;
      word_idx_d  = '0;
    end

    // A Gck edge coinciding with the latch belongs to the new interval
    if (gck_rise && gacc_d != GCK_MAX) gacc_d = gacc_d + 1'b1;
  end

  always_ff @(posedge CLK_60M or posedge RST) begin
    if (RST) begin
      dclk_q      <= '0;
      lat_q       <= '0;
      gck_q       <= '0;
      di_q        <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      word_idx_q  <= '0;
      lbits_q     <= '0;
      win_q       <= '0;
      gacc_q      <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_idx_q    <= '0;
      lat_event_q <= 1'b0;
      lat_type_q  <= 1'b0;
      lat_bits_q  <= '0;
      gck_cnt_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      dclk_q      <= {dclk_q[1:0], my9262_Dclk};
      lat_q       <= {lat_q[1:0], my9262_Lat};
      gck_q       <= {gck_q[1:0], my9262_Gck};
      di_q        <= {di_q[0], my9262_Di};
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      word_idx_q  <= word_idx_d;
      lbits_q     <= lbits_d;
      win_q       <= win_d;
      gacc_q      <= gacc_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_idx_q    <= rx_idx_d;
      lat_event_q <= lat_event_d;
      lat_type_q  <= lat_type_d;
      lat_bits_q  <= lat_bits_d;
      gck_cnt_q   <= gck_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_Data     = rx_data_q;
  assign rx_Valid    = rx_valid_q;
  assign rx_Word_Idx = rx_idx_q;
  assign lat_Event   = lat_event_q;
  assign lat_Type    = lat_type_q;
  assign lat_Bits    = lat_bits_q;
  assign gck_Cnt     = gck_cnt_q;
  assign frame_Err   = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_my9262_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_my9262_rx
// Brief    : Self-checking bench for my9262_rx (table vectors + random frames).
// Revision : 1.0
// ============================================================================
module tb_my9262_rx;

  localparam int OVR_EDGES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dclk = 1'b0, di = 1'b0, lat = 1'b0, gck = 1'b0;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic [4:0]  rx_idx;
  logic        lat_event, lat_type, frame_err;
  logic [9:0]  lat_bits;
  logic [15:0] gck_cnt;

  my9262_rx #(.WORD_W(16), .FRAME_WORDS(32), .OVR_EDGES(OVR_EDGES)) dut (
    .CLK_60M     (clk),
    .RST         (rst),
    .my9262_Dclk (dclk),
    .my9262_Di   (di),
    .my9262_Lat  (lat),
    .my9262_Gck  (gck),
    .rx_Data     (rx_data),
    .rx_Valid    (rx_valid),
    .rx_Word_Idx (rx_idx),
    .lat_Event   (lat_event),
    .lat_Type    (lat_type),
    .lat_Bits    (lat_bits),
    .gck_Cnt     (gck_cnt),
    .frame_Err   (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [15:0] data; logic [4:0] idx; int cyc; } rx_ev_t;
  typedef struct { logic typ; logic [9:0] bits; logic [15:0] gck; logic err; int cyc; } lat_ev_t;
  typedef struct {
    int nbits; int k; bit coinc; int latlen; int gckp; logic [15:0] base;
    int nvalid; logic typ; int bits; int gcnt; logic err;
  } vec_t;

  rx_ev_t  act_rx[$], exp_rx[$];
  lat_ev_t act_lat[$], exp_lat[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid)  act_rx.push_back('{rx_data, rx_idx, cyc});
      if (lat_event) act_lat.push_back('{lat_type, lat_bits, gck_cnt, frame_err, cyc});
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Transaction-level reference: pin events in, expected words/latches out
  int          m_nb, m_idx, m_bits, m_gck, m_win;
  logic        m_err;
  logic [15:0] m_word;
  logic        p_dclk, p_lat, p_gck;
  bit          rand_gck = 1'b0;
  logic [15:0] wds [0:79];

  task automatic model_reset();
    m_nb = 0; m_idx = 0; m_bits = 0; m_gck = 0; m_win = 0; m_err = 1'b0; m_word = '0;
    p_dclk = 1'b0; p_lat = 1'b0; p_gck = 1'b0;
  endtask

  task automatic drive(input logic d, input logic b, input logic l, input logic g);
    logic gg;
    gg = rand_gck ? 1'($urandom_range(0, 1)) : g;
    dclk = d; di = b; lat = l; gck = gg;
    if (l && !p_lat) m_win = 0;
    if (d && !p_dclk) begin
      m_word = {m_word[14:0], b};
      m_bits = (m_bits < 1023) ? m_bits + 1 : 1023;
      if (l || p_lat) m_win++;
      m_nb++;
      if (m_nb == 16) begin
        exp_rx.push_back('{m_word, 5'(m_idx), 0});
        m_idx = (m_idx + 1) % 32;
        m_nb  = 0;
      end
    end
    if (!l && p_lat) begin
      if (m_nb != 0) m_err = 1'b1;
      exp_lat.push_back('{1'(m_win >= OVR_EDGES), 10'(m_bits), 16'(m_gck), m_err, 0});
      m_nb = 0; m_idx = 0; m_bits = 0; m_gck = 0;
    end
    if (gg && !p_gck) m_gck = (m_gck < 65535) ? m_gck + 1 : 65535;
    p_dclk = d; p_lat = l; p_gck = gg;
    @(negedge clk);
  endtask

  // Dclk = clk/2; Lat is raised k bits before the end (overall) or pulsed
  // afterwards for latlen cycles; coinc drops Lat with the final Dclk rise.
  task automatic send_frame(input int nbits, input int k, input bit coinc,
                            input int latlen, input int gckp);
    logic b, l;
    for (int p = 0; p < gckp; p++) begin
      drive(0, 0, 0, 0); drive(0, 0, 0, 0); drive(0, 0, 0, 1); drive(0, 0, 0, 1);
    end
    for (int i = 0; i < nbits; i++) begin
      b = wds[i/16][15 - (i % 16)];
      l = (k > 0) && (i >= nbits - k);
      drive(0, b, l, 0);
      drive(1, b, (coinc && i == nbits - 1) ? 1'b0 : l, 0);
    end
    if (!coinc) begin
      if (k > 0) drive(0, 0, 0, 0);
      else begin
        drive(0, 0, 0, 0);
        repeat (latlen) drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
      end
    end
    repeat (8) drive(0, 0, 0, 0);
  endtask

  task automatic compare_queues(input string tag);
    rx_ev_t  a, e;
    lat_ev_t la, le;
    check({tag, " rx count"}, act_rx.size(), exp_rx.size());
    while (act_rx.size() > 0 && exp_rx.size() > 0) begin
      a = act_rx.pop_front(); e = exp_rx.pop_front();
      check({tag, " rx_Data"}, a.data, e.data);
      check({tag, " rx_Word_Idx"}, a.idx, e.idx);
    end
    check({tag, " lat count"}, act_lat.size(), exp_lat.size());
    while (act_lat.size() > 0 && exp_lat.size() > 0) begin
      la = act_lat.pop_front(); le = exp_lat.pop_front();
      check({tag, " lat_Type"}, la.typ, le.typ);
      check({tag, " lat_Bits"}, la.bits, le.bits);
      check({tag, " gck_Cnt"}, la.gck, le.gck);
      check({tag, " frame_Err"}, la.err, le.err);
    end
    act_rx.delete(); exp_rx.delete(); act_lat.delete(); exp_lat.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " rx_Data"}, rx_data, 0);
    check({tag, " rx_Valid"}, rx_valid, 0);
    check({tag, " rx_Word_Idx"}, rx_idx, 0);
    check({tag, " lat_Event"}, lat_event, 0);
    check({tag, " lat_Type"}, lat_type, 0);
    check({tag, " lat_Bits"}, lat_bits, 0);
    check({tag, " gck_Cnt"}, gck_cnt, 0);
    check({tag, " frame_Err"}, frame_err, 0);
  endtask

  vec_t tv [0:6];

  initial begin
    //        nbits k coinc latlen gckp base      nvalid typ bits gcnt err
    tv[0] = '{512, 0, 1'b0, 2, 0,   16'h0064, 32, 1'b0, 512, 0,   1'b0};
    tv[1] = '{512, 3, 1'b0, 0, 0,   16'h1234, 32, 1'b1, 512, 0,   1'b0};
    tv[2] = '{0,   0, 1'b0, 2, 100, 16'h0000, 0,  1'b0, 0,   100, 1'b0};
    tv[3] = '{16,  1, 1'b1, 0, 0,   16'hC0DE, 1,  1'b0, 16,  0,   1'b0};
    tv[4] = '{32,  2, 1'b1, 0, 0,   16'h7001, 2,  1'b1, 32,  0,   1'b0};
    tv[5] = '{20,  0, 1'b0, 2, 0,   16'hBEEF, 1,  1'b0, 20,  0,   1'b1};
    tv[6] = '{16,  0, 1'b0, 2, 0,   16'h0F0F, 1,  1'b0, 16,  0,   1'b1};

    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 80; j++) wds[j] = tv[i].base + 16'(j);
      send_frame(tv[i].nbits, tv[i].k, tv[i].coinc, tv[i].latlen, tv[i].gckp);
      check($sformatf("vec%0d valid count", i), act_rx.size(), tv[i].nvalid);
      check($sformatf("vec%0d lat count", i), act_lat.size(), 1);
      if (act_lat.size() > 0) begin
        check($sformatf("vec%0d lat_Type", i), act_lat[$].typ, tv[i].typ);
        check($sformatf("vec%0d lat_Bits", i), act_lat[$].bits, tv[i].bits);
        check($sformatf("vec%0d gck_Cnt", i), act_lat[$].gck, tv[i].gcnt);
        check($sformatf("vec%0d frame_Err", i), act_lat[$].err, tv[i].err);
        if (act_rx.size() > 0) begin
          check($sformatf("vec%0d last word before latch", i),
                act_rx[$].cyc <= act_lat[$].cyc, 1);
          if (tv[i].coinc)
            check($sformatf("vec%0d valid/latch same cycle", i),
                  act_lat[$].cyc - act_rx[$].cyc, 0);
        end
      end
      if (act_rx.size() > 0)
        check($sformatf("vec%0d first word", i), act_rx[0].data, tv[i].base);
      compare_queues($sformatf("vec%0d", i));
    end

    // Mid-word reset after 9 bits
    for (int i = 0; i < 9; i++) begin
      drive(0, 1, 0, 0);
      drive(1, 1, 0, 0);
    end
    check("pre-reset rx count", act_rx.size(), 0);
    rst = 1'b1;
    dclk = 1'b0; di = 1'b0; lat = 1'b0; gck = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("midword reset");
    rst = 1'b0;
    model_reset();
    act_rx.delete(); act_lat.delete(); exp_rx.delete(); exp_lat.delete();
    wds[0] = 16'hA5C3;
    send_frame(16, 0, 1'b0, 2, 0);
    check("post-reset valid count", act_rx.size(), 1);
    if (act_rx.size() > 0) begin
      check("post-reset rx_Data", act_rx[0].data, 16'hA5C3);
      check("post-reset rx_Word_Idx", act_rx[0].idx, 0);
    end
    compare_queues("post-reset");

    // Random frames with random Gck activity; last one long enough to
    // saturate lat_Bits and wrap the word index
    rand_gck = 1'b1;
    for (int it = 0; it < 25; it++) begin
      int nb, k, ll;
      bit co;
      nb = (it == 24) ? 1040 : int'($urandom_range(0, 70));
      k  = $urandom_range(0, 3);
      if (k > nb) k = nb;
      co = (k > 0) && ($urandom_range(0, 1) == 1);
      ll = $urandom_range(1, 3);
      for (int j = 0; j < 80; j++) wds[j] = 16'($urandom);
      send_frame(nb, k, co, ll, $urandom_range(0, 6));
      compare_queues($sformatf("rand%0d", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
